// File: rtl/ooo_queue_scheduler_pkg.sv
// ooo_queue_scheduler_pkg
// Shared types for the OOO-flow queue scheduler: flow ID, heap priority,
// heap occupancy, and the eviction FSM state encoding.
package ooo_queue_scheduler_pkg;

  localparam int OOO_FLOW_ID_AWIDTH   = 8;
  localparam int HEAP_PRIORITY_AWIDTH = 8;
  localparam int HEAP_SIZE_AWIDTH     = 6;

  typedef logic [OOO_FLOW_ID_AWIDTH-1:0]   ooo_flow_id_t;
  typedef logic [HEAP_PRIORITY_AWIDTH-1:0] heap_priority_t;
  typedef logic [HEAP_SIZE_AWIDTH-1:0]     heap_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } evict_state_t;

  // 32-bit increment that sticks at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ooo_queue_scheduler_if.sv
// ooo_queue_scheduler_if
// Bundle between the scheduler and the bounded OOO-flow queue.
//   master : scheduler side (drives enque and deque-max requests)
//   slave  : queue side (drives readiness, deque-max data, occupancy)
interface ooo_queue_scheduler_if;
  import ooo_queue_scheduler_pkg::*;

  logic           q_enque_en;
  ooo_flow_id_t   q_enque_ooo_flow_id;
  heap_priority_t q_enque_priority;
  logic           q_enque_ready;

  logic           q_deque_max_req_en;
  logic           q_deque_max_req_ready;
  logic           q_deque_max_en;
  ooo_flow_id_t   q_deque_max_ooo_flow_id;
  heap_priority_t q_deque_max_priority;
  logic           q_deque_max_ready;

  heap_size_t     q_queue_size;

  modport master (
    output q_enque_en, q_enque_ooo_flow_id, q_enque_priority,
    output q_deque_max_req_en, q_deque_max_en,
    input  q_enque_ready, q_deque_max_req_ready,
    input  q_deque_max_ooo_flow_id, q_deque_max_priority, q_deque_max_ready,
    input  q_queue_size
  );

  modport slave (
    input  q_enque_en, q_enque_ooo_flow_id, q_enque_priority,
    input  q_deque_max_req_en, q_deque_max_en,
    output q_enque_ready, q_deque_max_req_ready,
    output q_deque_max_ooo_flow_id, q_deque_max_priority, q_deque_max_ready,
    output q_queue_size
  );

endinterface

// File: rtl/ooo_queue_scheduler_rr_arbiter.sv
// ooo_queue_scheduler_rr_arbiter
// Round-robin arbiter. Search starts at rr_ptr; the pointer moves to
// winner+1 (mod NUM_REQ) only when advance is high with a grant present.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   req        : request vector
//   advance    : granted transfer accepted this cycle
//   grant      : one-hot grant (combinational)
//   winner     : index of granted requester
//   any_grant  : at least one request granted
module ooo_queue_scheduler_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int Q_WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [Q_WIDTH-1:0] winner,
  output logic               any_grant
);

  logic [Q_WIDTH-1:0] rr_ptr;

  // Two passes: indices at/above the pointer first, then the wrap-around.
  always_comb begin
    grant     = '0;
    winner    = '0;
    any_grant = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_grant && req[i] && (i >= int'(rr_ptr))) begin
        grant[i]  = 1'b1;
        winner    = Q_WIDTH'(i);
        any_grant = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_grant && req[i] && (i < int'(rr_ptr))) begin
        grant[i]  = 1'b1;
        winner    = Q_WIDTH'(i);
        any_grant = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (advance && any_grant) begin
      rr_ptr <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + Q_WIDTH'(1);
    end
  end

endmodule

// File: rtl/ooo_queue_scheduler.sv
// ooo_queue_scheduler
// Shares the OOO-flow queue enque port among NUM_REQ requesters (round-robin,
// zero-latency pass-through) and evicts the max-priority entry through the
// queue's deque-max port when occupancy reaches cfg_high_wm or on force_evict.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   req_valid/_ooo_flow_id/_priority, req_ready : requester enque side
//   qif (master)        : queue enque, deque-max and occupancy
//   cfg_evict_en, cfg_high_wm, force_evict      : eviction control
//   evict_valid/_ooo_flow_id/_priority, evict_ready : evicted entry out
//   evict_busy          : eviction FSM not idle
// Optional: define OOO_SCHED_STATS_EN to add stat_enques, stat_evicts and
// stat_enque_stalls (32-bit saturating counters).
//
// Eviction FSM
//   state | meaning
//   IDLE  | waiting for trigger (watermark or pending force)
//   REQ   | q_deque_max_req_en high until queue accepts
//   WAIT  | q_deque_max_en high until queue returns the entry
//   OUT   | evict_valid high until downstream takes it
module ooo_queue_scheduler
  import ooo_queue_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int Q_WIDTH = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic           [NUM_REQ-1:0]  req_valid,
  input  ooo_flow_id_t   [NUM_REQ-1:0]  req_ooo_flow_id,
  input  heap_priority_t [NUM_REQ-1:0]  req_priority,
  output logic           [NUM_REQ-1:0]  req_ready,
  ooo_queue_scheduler_if.master         qif,
  input  logic                          cfg_evict_en,
  input  heap_size_t                    cfg_high_wm,
  input  logic                          force_evict,
  output logic                          evict_valid,
  output ooo_flow_id_t                  evict_ooo_flow_id,
  output heap_priority_t                evict_priority,
  input  logic                          evict_ready,
  output logic                          evict_busy
`ifdef OOO_SCHED_STATS_EN
  ,
  output logic [31:0]                   stat_enques,
  output logic [31:0]                   stat_evicts,
  output logic [31:0]                   stat_enque_stalls
`endif
);

  logic [NUM_REQ-1:0] req_masked;
  logic [NUM_REQ-1:0] grant;
  logic [Q_WIDTH-1:0] winner;
  logic               any_grant;
  logic               enq_fire;
  ooo_flow_id_t       enq_id;
  heap_priority_t     enq_pri;

  // Requests are masked during reset so nothing is granted or accepted.
  assign req_masked = req_valid & {NUM_REQ{rst_n}};
  assign enq_fire   = any_grant & qif.q_enque_ready;

  ooo_queue_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .Q_WIDTH (Q_WIDTH)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_masked),
    .advance   (qif.q_enque_ready),
    .grant     (grant),
    .winner    (winner),
    .any_grant (any_grant)
  );

  always_comb begin
    enq_id  = '0;
    enq_pri = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (any_grant && (int'(winner) == i)) begin
        enq_id  = req_ooo_flow_id[i];
        enq_pri = req_priority[i];
      end
    end
  end

  assign req_ready               = grant & {NUM_REQ{qif.q_enque_ready}};
  assign qif.q_enque_en          = enq_fire;
  assign qif.q_enque_ooo_flow_id = enq_id;
  assign qif.q_enque_priority    = enq_pri;

  evict_state_t state;
  logic         force_pending;
  logic         deq_req_en;
  logic         deq_en;
  logic         size_nz;
  logic         wm_hit;
  logic         trigger;

  assign size_nz = (qif.q_queue_size != '0);
  assign wm_hit  = (cfg_high_wm != '0) && (qif.q_queue_size >= cfg_high_wm);
  assign trigger = cfg_evict_en && size_nz && (wm_hit || force_pending);

  assign qif.q_deque_max_req_en = deq_req_en;
  assign qif.q_deque_max_en     = deq_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      force_pending     <= 1'b0;
      deq_req_en        <= 1'b0;
      deq_en            <= 1'b0;
      evict_valid       <= 1'b0;
      evict_busy        <= 1'b0;
      evict_ooo_flow_id <= '0;
      evict_priority    <= '0;
    end else begin
      // A force that lands while an eviction is starting, or while the queue
      // is empty in IDLE, is absorbed rather than queued up.
      if ((state == IDLE) && (trigger || !size_nz)) begin
        force_pending <= 1'b0;
      end else if (force_evict) begin
        force_pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (trigger) begin
            state      <= REQ;
            deq_req_en <= 1'b1;
            evict_busy <= 1'b1;
          end
        end
        REQ: begin
          if (qif.q_deque_max_req_ready) begin
            state      <= WAIT;
            deq_req_en <= 1'b0;
            deq_en     <= 1'b1;
          end
        end
        WAIT: begin
          if (qif.q_deque_max_ready) begin
            state             <= OUT;
            deq_en            <= 1'b0;
            evict_valid       <= 1'b1;
            evict_ooo_flow_id <= qif.q_deque_max_ooo_flow_id;
            evict_priority    <= qif.q_deque_max_priority;
          end
        end
        OUT: begin
          if (evict_ready) begin
            state       <= IDLE;
            evict_valid <= 1'b0;
            evict_busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OOO_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_enques       <= '0;
      stat_evicts       <= '0;
      stat_enque_stalls <= '0;
    end else begin
      if (enq_fire) stat_enques <= sat_inc(stat_enques);
      if (evict_valid && evict_ready) stat_evicts <= sat_inc(stat_evicts);
      if ((|req_valid) && !qif.q_enque_ready) stat_enque_stalls <= sat_inc(stat_enque_stalls);
    end
  end
`endif

endmodule
